shift_left2: RTL and testbench

SHIFT_LEFT2 -- requirements
Module: shift_left2

---
 rtl/shift_left2.sv | 65 ++++++
 tb/tb_shift_left2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left2.sv
// Single-stage valid/ready pipeline that logically shifts an operand left by SHIFT
// bits and flags a signed overflow when the discarded bits are not sign copies.
module shift_left2 #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sign_extended,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] shifted,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  if (WIDTH < 2 || SHIFT < 1 || SHIFT > WIDTH - 1) begin : g_bad_param
    $error("shift_left2: illegal WIDTH/SHIFT combination");
  end

  logic [WIDTH-1:0] shifted_reg;
  logic [WIDTH-1:0] shifted_next;
  logic             overflow_reg;
  logic             overflow_next;
  logic             out_valid_reg;
  logic [SHIFT:0]   top_bits;
  logic             accept;

  // Low SHIFT result bits are zero; the rest come from the operand shifted up.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi < SHIFT) begin : g_zero
      assign shifted_next[gi] = 1'b0;
    end else begin : g_bit
      assign shifted_next[gi] = sign_extended[gi-SHIFT];
    end
  end

  // Result is representable only if every discarded bit equals the new sign bit.
  assign top_bits      = sign_extended[WIDTH-1 -: SHIFT+1];
  assign overflow_next = !((&top_bits) || !(|top_bits));

  // Reset term keeps the stage visibly ready while a held result is being discarded.
  assign in_ready = reset || !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      shifted_reg   <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      shifted_reg   <= shifted_next;
      overflow_reg  <= overflow_next;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign shifted   = shifted_reg;
  assign overflow  = overflow_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_left2.sv
// Scoreboard bench for shift_left2: default 32/2 instance plus a 16/1 instance.
module tb_shift_left2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] se32;
  logic        iv32, ir32, ov32, ovl32, ord32;
  logic [31:0] sh32;
  logic [15:0] se16;
  logic        iv16, ir16, ov16, ovl16, ord16;
  logic [15:0] sh16;

  int checks = 0;
  int errors = 0;
  logic [32:0] q32[$];
  logic [16:0] q16[$];

  always #5 clk = ~clk;

  shift_left2 u32 (
    .clk(clk), .reset(reset), .sign_extended(se32), .in_valid(iv32),
    .in_ready(ir32), .shifted(sh32), .overflow(ovl32), .out_valid(ov32),
    .out_ready(ord32)
  );

  shift_left2 #(.WIDTH(16), .SHIFT(1)) u16 (
    .clk(clk), .reset(reset), .sign_extended(se16), .in_valid(iv16),
    .in_ready(ir16), .shifted(sh16), .overflow(ovl16), .out_valid(ov16),
    .out_ready(ord16)
  );

  // Reference: arithmetic multiply by 4 in 64 bits, overflow if outside int32 range.
  function automatic logic [32:0] model32(input logic [31:0] x);
    longint v;
    logic   o;
    v = {{32{x[31]}}, x};
    v = v * 4;
    o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    return {o, v[31:0]};
  endfunction

  // Scoreboard: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ov32 && ord32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL out32_unexpected got shifted=%h overflow=%b required no output", sh32, ovl32);
      end else begin
        logic [32:0] e;
        e = q32.pop_front();
        if ({ovl32, sh32} !== e) begin
          errors++;
          $display("FAIL out32 got shifted=%h overflow=%b required shifted=%h overflow=%b",
                   sh32, ovl32, e[31:0], e[32]);
        end else
          $display("txn32 shifted=%h overflow=%b", sh32, ovl32);
      end
    end
    if (!reset && ov16 && ord16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL out16_unexpected got shifted=%h overflow=%b required no output", sh16, ovl16);
      end else begin
        logic [16:0] e;
        e = q16.pop_front();
        if ({ovl16, sh16} !== e) begin
          errors++;
          $display("FAIL out16 got shifted=%h overflow=%b required shifted=%h overflow=%b",
                   sh16, ovl16, e[15:0], e[16]);
        end else
          $display("txn16 shifted=%h overflow=%b", sh16, ovl16);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; se32 = '0; iv32 = 0; ord32 = 0; se16 = '0; iv16 = 0; ord16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov32, sh32, ovl32, ir32} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset32 got v=%b sh=%h ov=%b rdy=%b required v=0 sh=0 ov=0 rdy=1", ov32, sh32, ovl32, ir32);
    end
    checks++;
    if ({ov16, sh16, ovl16, ir16} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset16 got v=%b sh=%h ov=%b rdy=%b required v=0 sh=0 ov=0 rdy=1", ov16, sh16, ovl16, ir16);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready got rdy=%b v=%b required rdy=1 v=0", ir32, ov32);
    end
  endtask

  task automatic test_stream;
    logic [31:0] ins[6] = '{32'hFFFFFFFF, 32'hFFFF7FFF, 32'hFFFFBFFF, 32'hFFFFDFFF, 32'hFFFF6FFF, 32'hFFFF7BFF};
    logic [31:0] exp[6] = '{32'hFFFFFFFC, 32'hFFFDFFFC, 32'hFFFEFFFC, 32'hFFFF7FFC, 32'hFFFDBFFC, 32'hFFFDEFFC};
    int cnt = 0;
    ord32 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      se32 = ins[i]; iv32 = 1'b1; q32.push_back({1'b0, exp[i]});
      @(posedge clk); #1;
      if (ov32) cnt++;
    end
    iv32 = 1'b0;
    // Full throughput: out_valid must be high right after each of the six accepts.
    checks++;
    if (cnt != 6) begin
      errors++;
      $display("FAIL stream_throughput got %0d valid cycles required 6", cnt);
    end
    for (int i = 0; i < 20 && q32.size() != 0; i++) @(negedge clk);
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL stream_drain got %0d pending required 0", q32.size());
    end
  endtask

  task automatic test_overflow;
    logic [31:0] ins[4] = '{32'h40000000, 32'h20000000, 32'hE0000000, 32'h00000001};
    logic [32:0] exp[4] = '{{1'b1, 32'h00000000}, {1'b1, 32'h80000000},
                            {1'b0, 32'h80000000}, {1'b0, 32'h00000004}};
    ord32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      se32 = ins[i]; iv32 = 1'b1; q32.push_back(exp[i]);
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    for (int i = 0; i < 20 && q32.size() != 0; i++) @(negedge clk);
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain got %0d pending required 0", q32.size());
    end
  endtask

  task automatic test_backpressure;
    ord32 = 1'b1; se32 = 32'h3; iv32 = 1'b1; q32.push_back({1'b0, 32'hC});
    @(posedge clk); #1;
    ord32 = 1'b0; se32 = 32'h5; q32.push_back({1'b0, 32'h14});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ir32 !== 1'b0 || ov32 !== 1'b1 || sh32 !== 32'hC || ovl32 !== 1'b0) begin
        errors++;
        $display("FAIL stall got rdy=%b v=%b sh=%h ov=%b required rdy=0 v=1 sh=0000000c ov=0", ir32, ov32, sh32, ovl32);
      end
      @(posedge clk); #1;
    end
    ord32 = 1'b1;
    @(negedge clk);
    checks++;
    if (ir32 !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b required 1", ir32);
    end
    @(posedge clk); #1 iv32 = 1'b0;
    @(negedge clk);
    checks++;
    if (ov32 !== 1'b1 || sh32 !== 32'h14) begin
      errors++;
      $display("FAIL release_result got v=%b sh=%h required v=1 sh=00000014", ov32, sh32);
    end
    for (int i = 0; i < 20 && q32.size() != 0; i++) @(negedge clk);
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d pending required 0", q32.size());
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    ord32 = 1'b0; se32 = 32'h80000007; iv32 = 1'b1; q32.push_back(model32(32'h80000007));
    @(posedge clk); #1;
    iv32 = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ir32 !== 1'b1) begin
      errors++;
      $display("FAIL ready_in_reset got %b required 1", ir32);
    end
    @(posedge clk); #1;
    reset = 1'b0; q32.delete();
    @(negedge clk);
    checks++;
    if ({ov32, sh32, ovl32, ir32} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got v=%b sh=%h ov=%b rdy=%b required v=0 sh=0 ov=0 rdy=1", ov32, sh32, ovl32, ir32);
    end
    @(posedge clk); #1 ord32 = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (acc) iv32 = 1'b0;
      if (!iv32 && $urandom_range(0, 3) != 0) begin
        se32 = (i % 5 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
        iv32 = 1'b1;
        q32.push_back(model32(se32));
      end
      ord32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = iv32 && ir32;
      checks++;
      if (ir32 !== (!ov32 || ord32)) begin
        errors++;
        $display("FAIL ready_rule got %b required %b", ir32, !ov32 || ord32);
      end
    end
    @(posedge clk); #1;
    ord32 = 1'b1;
    if (acc) iv32 = 1'b0;
    @(posedge clk); #1 iv32 = 1'b0;
    for (int i = 0; i < 20 && q32.size() != 0; i++) @(negedge clk);
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d pending required 0", q32.size());
    end
  endtask

  task automatic test_width16;
    ord16 = 1'b1;
    se16 = 16'hC001; iv16 = 1'b1; q16.push_back({1'b0, 16'h8002});
    @(posedge clk); #1;
    se16 = 16'h4000; q16.push_back({1'b1, 16'h8000});
    @(posedge clk); #1 iv16 = 1'b0;
    for (int i = 0; i < 20 && q16.size() != 0; i++) @(negedge clk);
    checks++;
    if (q16.size() != 0) begin
      errors++;
      $display("FAIL w16_drain got %0d pending required 0", q16.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_width16();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
